bsg_mem_1r1w_sync_mask_init: RTL and testbench
==============================================

Name: bsg_mem_1r1w_sync_mask_init

Overview:
- Parametrised successor to the 2-entry, 16-bit flop-based 1r1w memory.
- Generalised width and depth; adds per-byte write mask, a registered (synchronous) read port with valid, a selectable same-address read/write policy, and a post-reset zero-initialisation sweep.
- Used wherever small flop arrays (tag/valid/metadata) must come out of reset in a known state.

Parameters:
- width_p, 16, data width in bits; must be a multiple of mask_gran_p.
- els_p, 2, number of entries; ≥2, need not be a power of two.
- mask_gran_p, 8, bits per write-mask bit.
- read_write_same_addr_p, 0, same-cycle same-address policy: 0 = read returns old data, 1 = read returns newly written data.
- Derived: addr_width_lp = max(1, clog2(els_p)); mask_width_lp = width_p / mask_gran_p.

Ports:
- clk_i  in  1  single clock for all state; all behaviour is on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- ready_o  out  1  high when the initialisation sweep is done and the ports accept traffic.
- w_v_i  in  1  write request.
- w_addr_i  in  addr_width_lp  write address.
- w_data_i  in  width_p  write data.
- w_mask_i  in  mask_width_lp  write mask; bit k enables data bits [k*mask_gran_p +: mask_gran_p].
- r_v_i  in  1  read request.
- r_addr_i  in  addr_width_lp  read address.
- r_v_o  out  1  read data valid, one cycle after the accepted r_v_i.
- r_data_o  out  width_p  registered read data.

Behaviour:
Reset is synchronous and active-low:
- Sampled low at a rising edge: state <= INIT, init_cnt <= 0, ready_o <= 0, r_v_o <= 0, r_data_o <= 0.
- Memory contents are not reset directly; the INIT sweep clears them.
- Reset asserted mid-sweep or mid-operation restarts INIT from entry 0.

FSM, two states:
- INIT: each cycle writes all-zeros to entry init_cnt, then init_cnt++.
  - When init_cnt == els_p-1, that write completes and state goes to READY. ready_o = 1 from the next cycle.
  - The sweep takes exactly els_p cycles after reset deasserts.
  - w_v_i and r_v_i are ignored in INIT; r_v_o stays 0 and r_data_o stays 0.
- READY: stays in READY until reset.

Write (READY):
- When w_v_i = 1, bits of entry w_addr_i whose mask bit is 1 take w_data_i at the edge; masked-off bits are unchanged.
- w_mask_i = 0 is a no-op.
- w_addr_i ≥ els_p: the write is dropped.

Read (READY):
- When r_v_i = 1 at edge n: after edge n, r_data_o = mem[r_addr_i] and r_v_o = 1. Latency is 1 cycle.
- When r_v_i = 0: r_v_o <= 0 and r_data_o holds its previous value.
- r_addr_i ≥ els_p: r_data_o <= 0 and r_v_o <= 1.

Same-address collision (r_v_i & w_v_i & r_addr_i == w_addr_i, in range):
- p=0: r_data_o gets the pre-write contents.
- p=1: r_data_o gets the merged value, i.e. (old & ~bitmask) | (w_data_i & bitmask).
- Different addresses: the write and the read are independent.

Other rules:
- No combinational path from any input to any output.
- ready_o depends only on state.

Test Plan (width_p=16, els_p=3, mask_gran_p=8):
1. Reset sweep: hold reset_n_i low 2 cycles, then release.
   -> ready_o = 0 for exactly 3 cycles, then 1.
   -> Reads of addr 0..2 then return 0x0000 with r_v_o pulsing 1 cycle after each r_v_i.
2. Masked write: write addr 1, data 0xABCD, mask 2'b11; then data 0x1234, mask 2'b01; then read addr 1.
   -> Next cycle r_data_o = 0xAB34, r_v_o = 1.
   -> With r_v_i = 0 the following cycle: r_v_o = 0 and r_data_o holds 0xAB34.
3. Collision, p=0 and p=1: mem[2] = 0x5555; same cycle write addr 2, data 0xFFFF, mask 2'b10, and read addr 2.
   -> p=0: r_data_o = 0x5555. p=1: r_data_o = 0xFF55.
   -> A read of addr 2 on the next cycle returns 0xFF55 in both cases.
4. Out of range: write addr 3, data 0x9999, mask 2'b11; then read addr 3, then read addr 0..2.
   -> Read of addr 3 gives r_data_o = 0x0000, r_v_o = 1.
   -> Entries 0..2 are unchanged.
5. Reset mid-sweep and mid-traffic:
   -> Write 0x7777 to addr 0; assert reset_n_i low 1 cycle; release.
      -> ready_o = 0 for 3 cycles; addr 0 reads 0x0000.
   -> Assert reset at cycle 2 of a sweep.
      -> The sweep restarts and takes a full 3 cycles after release.
6. INIT ignores traffic: drive w_v_i = 1 (addr 0, 0xFFFF, mask 2'b11) and r_v_i = 1 throughout INIT.
   -> r_v_o stays 0.
   -> After ready_o rises, addr 0 reads 0x0000.

Source files
------------

// File: rtl/bsg_mem_1r1w_sync_mask_init.sv
// Small flop-array memory: one masked write port, one registered read port,
// and a post-reset sweep that zeroes every entry before traffic is accepted.
module bsg_mem_1r1w_sync_mask_init #(
  parameter int width_p                = 16,
  parameter int els_p                  = 2,
  parameter int mask_gran_p            = 8,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp = (els_p > 2) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = width_p / mask_gran_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     ready_o,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_v_o,
  output logic [width_p-1:0]       r_data_o
);

  typedef enum logic {INIT, READY} state_e;

  localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp + 1)'(els_p);
  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);

  state_e                   state_reg, state_next;
  logic [addr_width_lp-1:0] init_cnt_reg, init_cnt_next;

  logic [width_p-1:0] mem_reg [els_p];

  logic [width_p-1:0]       bit_mask, w_old, w_merged, r_word;
  logic [addr_width_lp-1:0] w_idx, r_idx;
  logic                     w_in_range, r_in_range;
  logic                     init_we, write_en, read_en, collide;

  // Expand each mask bit over its granule of data bits.
  for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_mask
    assign bit_mask[gi*mask_gran_p +: mask_gran_p] = {mask_gran_p{w_mask_i[gi]}};
  end

  assign w_in_range = {1'b0, w_addr_i} < els_lp;
  assign r_in_range = {1'b0, r_addr_i} < els_lp;
  // Clamp indices so the array is never addressed past its end.
  assign w_idx      = w_in_range ? w_addr_i : '0;
  assign r_idx      = r_in_range ? r_addr_i : '0;

  assign ready_o  = (state_reg == READY);
  assign init_we  = reset_n_i && (state_reg == INIT);
  assign write_en = reset_n_i && ready_o && w_v_i && w_in_range && (|w_mask_i);
  assign read_en  = ready_o && r_v_i;
  assign collide  = w_v_i && r_v_i && w_in_range && r_in_range && (w_addr_i == r_addr_i);

  assign w_old    = mem_reg[w_idx];
  assign w_merged = (w_old & ~bit_mask) | (w_data_i & bit_mask);

  always_comb begin
    r_word = mem_reg[r_idx];
    if (!r_in_range) begin
      r_word = '0;
    end else if ((read_write_same_addr_p != 0) && collide) begin
      r_word = w_merged;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      INIT: begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == last_lp) begin
          state_next = READY;
        end
      end
      READY: state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      r_v_o        <= 1'b0;
      r_data_o     <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      r_v_o        <= read_en;
      if (read_en) begin
        r_data_o <= r_word;
      end
    end
  end

  // Storage has no reset of its own; the sweep is what clears it.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_reg[init_cnt_reg] <= '0;
    end else if (write_en) begin
      mem_reg[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_init.sv
// Directed bench: two instances (old-data and new-data collision policy)
// driven in lockstep, checked with immediate assertions.
module tb_bsg_mem_1r1w_sync_mask_init;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        w_v_i;
  logic [1:0]  w_addr_i;
  logic [15:0] w_data_i;
  logic [1:0]  w_mask_i;
  logic        r_v_i;
  logic [1:0]  r_addr_i;

  logic        ready0, ready1, rv0, rv1;
  logic [15:0] rdata0, rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bsg_mem_1r1w_sync_mask_init #(
    .width_p(16), .els_p(3), .mask_gran_p(8), .read_write_same_addr_p(0)
  ) u_dut0 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .ready_o(ready0),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_v_o(rv0), .r_data_o(rdata0)
  );

  bsg_mem_1r1w_sync_mask_init #(
    .width_p(16), .els_p(3), .mask_gran_p(8), .read_write_same_addr_p(1)
  ) u_dut1 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .ready_o(ready1),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_v_o(rv1), .r_data_o(rdata1)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, "/ready0"}, {31'd0, ready0}, {31'd0, exp});
    chk({tag, "/ready1"}, {31'd0, ready1}, {31'd0, exp});
  endtask

  task automatic chk_rd(input string tag, input logic exp_v,
                        input logic [15:0] exp0, input logic [15:0] exp1);
    chk({tag, "/rv0"},    {31'd0, rv0},    {31'd0, exp_v});
    chk({tag, "/rv1"},    {31'd0, rv1},    {31'd0, exp_v});
    chk({tag, "/rdata0"}, {16'd0, rdata0}, {16'd0, exp0});
    chk({tag, "/rdata1"}, {16'd0, rdata1}, {16'd0, exp1});
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] m);
    w_v_i = 1'b1; w_addr_i = a; w_data_i = d; w_mask_i = m;
    tick();
    w_v_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    r_v_i = 1'b1; r_addr_i = a;
    tick();
    r_v_i = 1'b0;
    chk_rd(tag, 1'b1, exp, exp);
  endtask

  task automatic release_and_sweep(input string tag);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ready(tag, 1'b0);
      tick();
    end
    chk_ready(tag, 1'b1);
  endtask

  initial begin
    reset_n_i = 1'b0;
    w_v_i = 1'b0; w_addr_i = '0; w_data_i = '0; w_mask_i = '0;
    r_v_i = 1'b0; r_addr_i = '0;

    // 1. reset and sweep, then everything reads zero
    tick();
    tick();
    chk_ready("rst", 1'b0);
    chk_rd("rst", 1'b0, 16'h0000, 16'h0000);
    release_and_sweep("sweep");
    rd("init_a0", 2'd0, 16'h0000);
    rd("init_a1", 2'd1, 16'h0000);
    rd("init_a2", 2'd2, 16'h0000);

    // 2. masked write, then idle cycle holds data
    wr(2'd1, 16'hABCD, 2'b11);
    wr(2'd1, 16'h1234, 2'b01);
    rd("mask_a1", 2'd1, 16'hAB34);
    tick();
    chk_rd("idle_hold", 1'b0, 16'hAB34, 16'hAB34);

    // 3. same-address collision
    wr(2'd2, 16'h5555, 2'b11);
    w_v_i = 1'b1; w_addr_i = 2'd2; w_data_i = 16'hFFFF; w_mask_i = 2'b10;
    r_v_i = 1'b1; r_addr_i = 2'd2;
    tick();
    w_v_i = 1'b0; r_v_i = 1'b0;
    chk_rd("collide", 1'b1, 16'h5555, 16'hFF55);
    rd("after_collide", 2'd2, 16'hFF55);

    // 4. out-of-range write dropped, out-of-range read gives zero
    wr(2'd3, 16'h9999, 2'b11);
    rd("oor_rd", 2'd3, 16'h0000);
    rd("oor_a0", 2'd0, 16'h0000);
    rd("oor_a1", 2'd1, 16'hAB34);
    rd("oor_a2", 2'd2, 16'hFF55);

    // 5a. reset during traffic clears memory
    wr(2'd0, 16'h7777, 2'b11);
    rd("pre_rst_a0", 2'd0, 16'h7777);
    reset_n_i = 1'b0;
    tick();
    chk_rd("rst2", 1'b0, 16'h0000, 16'h0000);
    release_and_sweep("resweep");
    rd("rst_a0", 2'd0, 16'h0000);
    rd("rst_a1", 2'd1, 16'h0000);

    // 5b. reset at cycle 2 of a sweep restarts it
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();
    chk_ready("mid_sweep", 1'b0);
    reset_n_i = 1'b0;
    tick();
    release_and_sweep("restart");

    // 6. traffic during INIT is ignored
    reset_n_i = 1'b0;
    tick();
    w_v_i = 1'b1; w_addr_i = 2'd0; w_data_i = 16'hFFFF; w_mask_i = 2'b11;
    r_v_i = 1'b1; r_addr_i = 2'd0;
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ready("init_busy", 1'b0);
      chk_rd("init_busy", 1'b0, 16'h0000, 16'h0000);
      tick();
    end
    chk_ready("init_busy_done", 1'b1);
    chk_rd("init_busy_done", 1'b0, 16'h0000, 16'h0000);
    w_v_i = 1'b0; r_v_i = 1'b0;
    rd("init_busy_a0", 2'd0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
